keypad_entry_buffer: RTL and testbench

Downstream consumer of the keypad interface's encoded key stream. Turns the level-style `key_pressed` flag and 4-bit `key_code` into exactly one action per physical press. It accumulates up to `DIGITS` decimal digits in a BCD entry register, supporting backspace and clear. On enter it hands the finished entry to the next stage through a valid/ready handshake.

---
 rtl/keypad_pkg.sv | 24 ++
 rtl/key_press_qualifier.sv | 110 +++++++++++
 rtl/keypad_entry_buffer.sv | 128 ++++++++++++
 tb/tb_keypad_entry_buffer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared key codes, qualifier state encoding and limits for the keypad entry path.
package keypad_pkg;

  localparam int unsigned KEY_W      = 4;
  localparam int unsigned DIGITS_MAX = 8;

  localparam logic [KEY_W-1:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [KEY_W-1:0] KEY_BKSP      = 4'hA;
  localparam logic [KEY_W-1:0] KEY_CLR       = 4'hE;
  localparam logic [KEY_W-1:0] KEY_ENTER     = 4'hF;

  typedef enum logic [1:0] {
    QS_IDLE    = 2'd0,
    QS_SETTLE  = 2'd1,
    QS_HELD    = 2'd2,
    QS_RELEASE = 2'd3
  } qual_state_e;

  // Codes 0x0..0x9 are decimal digits.
  function automatic logic is_digit(input logic [KEY_W-1:0] code);
    return code <= KEY_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/key_press_qualifier.sv
// Press qualifier: turns the level key_pressed into one press_c pulse per
// physical press, after SETTLE_CYCLES consecutive high samples, and re-arms
// only after RELEASE_CYCLES consecutive low samples.
//   clk, reset      : clock, async active-low reset
//   key_pressed     : level from the keypad interface
//   key_code        : encoded key, stable by the accepting edge
//   press_c         : high during the cycle whose edge accepts the press
//   press_code_c    : key code presented with press_c (zero otherwise)
module key_press_qualifier
  import keypad_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned RELEASE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_pressed,
  input  logic [KEY_W-1:0] key_code,
  output logic             press_c,
  output logic [KEY_W-1:0] press_code_c
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > RELEASE_CYCLES) ? SETTLE_CYCLES : RELEASE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_N  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] RELEASE_N = CNT_W'(RELEASE_CYCLES);

  qual_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  // Saturating increment of the shared settle/release counter.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

  // State and counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= QS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; the first sample of a run counts as 1, so a threshold of 1
  // is met directly from IDLE/HELD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_c = 1'b0;
    unique case (state_q)
      QS_IDLE: begin
        if (key_pressed) begin
          if (CNT_ONE >= SETTLE_N) begin
            state_d = QS_HELD;
            cnt_d   = '0;
            press_c = 1'b1;
          end else begin
            state_d = QS_SETTLE;
            cnt_d   = CNT_ONE;
          end
        end
      end
      QS_SETTLE: begin
        if (!key_pressed) begin
          state_d = QS_IDLE;
          cnt_d   = '0;
        end else if (cnt_inc >= SETTLE_N) begin
          state_d = QS_HELD;
          cnt_d   = '0;
          press_c = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      QS_HELD: begin
        if (!key_pressed) begin
          if (CNT_ONE >= RELEASE_N) begin
            state_d = QS_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = QS_RELEASE;
            cnt_d   = CNT_ONE;
          end
        end
      end
      QS_RELEASE: begin
        if (key_pressed) begin
          state_d = QS_HELD;
          cnt_d   = '0;
        end else if (cnt_inc >= RELEASE_N) begin
          state_d = QS_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = QS_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign press_code_c = press_c ? key_code : '0;

endmodule

// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: qualifies presses, edits a BCD entry register
// (digit shift-in, backspace, clear) and hands finished entries downstream
// over a valid/ready handshake.
//   clk, reset             : clock, async active-low reset
//   key_pressed, key_code  : raw key stream from the keypad interface
//   entry_bcd, entry_count : live entry, newest digit in nibble 0
//   key_event              : one pulse per accepted press
//   entry_err              : pulse on a digit press while full
//   out_valid, out_ready   : handshake for out_bcd
//   out_bcd                : finished entry, held until the next accepted enter
module keypad_entry_buffer
  import keypad_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned RELEASE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_pressed,
  input  logic [KEY_W-1:0]    key_code,
  output logic [4*DIGITS-1:0] entry_bcd,
  output logic [3:0]          entry_count,
  output logic                key_event,
  output logic                entry_err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd
);

  localparam int unsigned ENTRY_W = 4 * DIGITS;
  localparam int unsigned COUNT_W = 4;
  localparam logic [COUNT_W-1:0] DIGITS_N  = COUNT_W'(DIGITS);
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  if (DIGITS < 1 || DIGITS > DIGITS_MAX) begin : g_bad_digits
    $error("keypad_entry_buffer: DIGITS out of range");
  end

  logic             press_c;
  logic [KEY_W-1:0] press_code_c;

  logic [ENTRY_W-1:0] entry_d, out_bcd_d;
  logic [COUNT_W-1:0] count_d;
  logic               event_d, err_d, valid_d;

  key_press_qualifier #(
    .SETTLE_CYCLES  (SETTLE_CYCLES),
    .RELEASE_CYCLES (RELEASE_CYCLES)
  ) u_qual (
    .clk          (clk),
    .reset        (reset),
    .key_pressed  (key_pressed),
    .key_code     (key_code),
    .press_c      (press_c),
    .press_code_c (press_code_c)
  );

  // Action decode; enter is judged against the pre-edge out_valid so an
  // enter coinciding with acceptance is ignored while the acceptance completes.
  always_comb begin
    entry_d   = entry_bcd;
    count_d   = entry_count;
    event_d   = 1'b0;
    err_d     = 1'b0;
    valid_d   = out_valid;
    out_bcd_d = out_bcd;

    if (out_valid && out_ready) begin
      valid_d = 1'b0;
    end

    if (press_c) begin
      event_d = 1'b1;
      if (is_digit(press_code_c)) begin
        if (entry_count < DIGITS_N) begin
          entry_d = (entry_bcd << 4) | ENTRY_W'(press_code_c);
          count_d = entry_count + COUNT_ONE;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        unique case (press_code_c)
          KEY_BKSP: begin
            if (entry_count != '0) begin
              entry_d = entry_bcd >> 4;
              count_d = entry_count - COUNT_ONE;
            end
          end
          KEY_CLR: begin
            entry_d = '0;
            count_d = '0;
          end
          KEY_ENTER: begin
            if (entry_count != '0 && !out_valid) begin
              out_bcd_d = entry_bcd;
              valid_d   = 1'b1;
              entry_d   = '0;
              count_d   = '0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_bcd   <= '0;
      entry_count <= '0;
      key_event   <= 1'b0;
      entry_err   <= 1'b0;
      out_valid   <= 1'b0;
      out_bcd     <= '0;
    end else begin
      entry_bcd   <= entry_d;
      entry_count <= count_d;
      key_event   <= event_d;
      entry_err   <= err_d;
      out_valid   <= valid_d;
      out_bcd     <= out_bcd_d;
    end
  end

endmodule

// File: tb/tb_keypad_entry_buffer.sv
module tb_keypad_entry_buffer;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned SETTLE  = 4;
  localparam int unsigned RELEASE = 4;
  localparam int unsigned W       = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_pressed;
  logic [3:0]   key_code;
  logic [W-1:0] entry_bcd;
  logic [3:0]   entry_count;
  logic         key_event;
  logic         entry_err;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_bcd;

  always #50 clk = ~clk;

  keypad_entry_buffer #(
    .DIGITS         (DIGITS),
    .SETTLE_CYCLES  (SETTLE),
    .RELEASE_CYCLES (RELEASE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_pressed (key_pressed),
    .key_code    (key_code),
    .entry_bcd   (entry_bcd),
    .entry_count (entry_count),
    .key_event   (key_event),
    .entry_err   (entry_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bcd     (out_bcd)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: digits as a list, newest last.
  int           m_q[$];
  bit           m_ov;
  logic [W-1:0] m_ob;
  bit           m_err;

  function automatic logic [W-1:0] m_entry();
    logic [W-1:0] v = '0;
    foreach (m_q[i]) v = (v << 4) | W'(m_q[i]);
    return v;
  endfunction

  function automatic void m_reset();
    m_q.delete();
    m_ov  = 1'b0;
    m_ob  = '0;
    m_err = 1'b0;
  endfunction

  function automatic void m_apply(input logic [3:0] code, input bit pre_ov);
    if (code <= 4'h9) begin
      if (m_q.size() < DIGITS) m_q.push_back(int'(code));
      else m_err = 1'b1;
    end else if (code == 4'hA) begin
      if (m_q.size() > 0) void'(m_q.pop_back());
    end else if (code == 4'hE) begin
      m_q.delete();
    end else if (code == 4'hF) begin
      if (m_q.size() > 0 && !pre_ov) begin
        m_ob = m_entry();
        m_ov = 1'b1;
        m_q.delete();
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  task automatic chk_model();
    chk("entry_err",   32'(entry_err),   32'(m_err));
    chk("entry_bcd",   32'(entry_bcd),   32'(m_entry()));
    chk("entry_count", 32'(entry_count), 32'(m_q.size()));
    chk("out_valid",   32'(out_valid),   32'(m_ov));
    chk("out_bcd",     32'(out_bcd),     32'(m_ob));
  endtask

  // One clock: drive at negedge, sample 1 ns after posedge, update model.
  task automatic step(input logic kp, input logic [3:0] code, input logic rdy, input bit ev);
    bit pre_ov;
    @(negedge clk);
    key_pressed = kp;
    key_code    = code;
    out_ready   = rdy;
    @(posedge clk);
    #1;
    pre_ov = m_ov;
    m_err  = 1'b0;
    if (ev && reset) m_apply(code, pre_ov);
    if (pre_ov && rdy && reset) m_ov = 1'b0;
    chk("key_event", 32'(key_event), 32'(ev && reset));
    chk_model();
  endtask

  function automatic logic pick_rdy(input int mode);
    if (mode == 2) return logic'($urandom_range(0, 1));
    return logic'(mode);
  endfunction

  // A press held for `hold` cycles then released for `gap` cycles; the
  // event is expected on the SETTLE-th high sample.
  task automatic press(input logic [3:0] code, input int hold, input int gap, input int rdy_mode);
    for (int k = 1; k <= hold; k++) step(1'b1, code, pick_rdy(rdy_mode), k == SETTLE);
    for (int k = 0; k < gap; k++)   step(1'b0, code, pick_rdy(rdy_mode), 1'b0);
  endtask

  typedef struct {
    logic [3:0]   code;
    int           hold;
    int           rdy;
    logic [W-1:0] e_entry;
    logic [3:0]   e_cnt;
    bit           e_ov;
    logic [W-1:0] e_ob;
  } vec_t;

  vec_t tbl[$];

  initial begin
    reset       = 1'b0;
    key_pressed = 1'b0;
    key_code    = 4'h0;
    out_ready   = 1'b0;
    m_reset();

    tbl.push_back('{4'h1, 6, 0, 16'h0001, 4'd1, 1'b0, 16'h0000});
    tbl.push_back('{4'h2, 6, 0, 16'h0012, 4'd2, 1'b0, 16'h0000});
    tbl.push_back('{4'h3, 6, 0, 16'h0123, 4'd3, 1'b0, 16'h0000});
    tbl.push_back('{4'h5, 3, 0, 16'h0123, 4'd3, 1'b0, 16'h0000});
    tbl.push_back('{4'hE, 5, 0, 16'h0000, 4'd0, 1'b0, 16'h0000});
    tbl.push_back('{4'hF, 5, 0, 16'h0000, 4'd0, 1'b0, 16'h0000});
    tbl.push_back('{4'h9, 5, 0, 16'h0009, 4'd1, 1'b0, 16'h0000});
    tbl.push_back('{4'h8, 5, 0, 16'h0098, 4'd2, 1'b0, 16'h0000});
    tbl.push_back('{4'h7, 5, 0, 16'h0987, 4'd3, 1'b0, 16'h0000});
    tbl.push_back('{4'h6, 5, 0, 16'h9876, 4'd4, 1'b0, 16'h0000});
    tbl.push_back('{4'h5, 5, 0, 16'h9876, 4'd4, 1'b0, 16'h0000});
    tbl.push_back('{4'hA, 5, 0, 16'h0987, 4'd3, 1'b0, 16'h0000});
    tbl.push_back('{4'hE, 4, 0, 16'h0000, 4'd0, 1'b0, 16'h0000});
    tbl.push_back('{4'h4, 4, 0, 16'h0004, 4'd1, 1'b0, 16'h0000});
    tbl.push_back('{4'h2, 7, 0, 16'h0042, 4'd2, 1'b0, 16'h0000});
    tbl.push_back('{4'hF, 5, 0, 16'h0000, 4'd0, 1'b1, 16'h0042});
    tbl.push_back('{4'h7, 5, 0, 16'h0007, 4'd1, 1'b1, 16'h0042});
    tbl.push_back('{4'hF, 5, 0, 16'h0007, 4'd1, 1'b1, 16'h0042});
    tbl.push_back('{4'h0, 0, 1, 16'h0007, 4'd1, 1'b0, 16'h0042});

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst key_event",   32'(key_event),   32'h0);
    chk("rst entry_err",   32'(entry_err),   32'h0);
    chk("rst entry_bcd",   32'(entry_bcd),   32'h0);
    chk("rst entry_count", 32'(entry_count), 32'h0);
    chk("rst out_valid",   32'(out_valid),   32'h0);
    chk("rst out_bcd",     32'(out_bcd),     32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table.
    foreach (tbl[i]) begin
      press(tbl[i].code, tbl[i].hold, RELEASE, tbl[i].rdy);
      chk($sformatf("tbl%0d entry", i), 32'(entry_bcd),   32'(tbl[i].e_entry));
      chk($sformatf("tbl%0d count", i), 32'(entry_count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d valid", i), 32'(out_valid),   32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d obcd",  i), 32'(out_bcd),     32'(tbl[i].e_ob));
    end

    // Two-cycle drop while held must not produce a second event.
    for (int k = 1; k <= 6; k++) step(1'b1, 4'h8, 1'b0, k == SETTLE);
    repeat (2) step(1'b0, 4'h8, 1'b0, 1'b0);
    repeat (4) step(1'b1, 4'h8, 1'b0, 1'b0);
    repeat (RELEASE) step(1'b0, 4'h8, 1'b0, 1'b0);
    chk("drop entry", 32'(entry_bcd), 32'h0078);

    // Enter arriving on the same edge as acceptance is ignored.
    press(4'hF, 5, RELEASE, 0);
    chk("load valid", 32'(out_valid), 32'h1);
    chk("load obcd",  32'(out_bcd),   32'h0078);
    press(4'h3, 5, RELEASE, 0);
    for (int k = 1; k <= 6; k++) step(1'b1, 4'hF, logic'(k == SETTLE), k == SETTLE);
    repeat (RELEASE) step(1'b0, 4'hF, 1'b0, 1'b0);
    chk("collide valid", 32'(out_valid), 32'h0);
    chk("collide entry", 32'(entry_bcd), 32'h0003);

    // Reset mid-settle with the key held; a fresh full settle is needed.
    repeat (2) step(1'b1, 4'h4, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    m_reset();
    chk("async entry_bcd",   32'(entry_bcd),   32'h0);
    chk("async entry_count", 32'(entry_count), 32'h0);
    chk("async out_bcd",     32'(out_bcd),     32'h0);
    chk("async out_valid",   32'(out_valid),   32'h0);
    repeat (2) step(1'b1, 4'h4, 1'b0, 1'b0);
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) step(1'b1, 4'h4, 1'b0, k == SETTLE);
    repeat (RELEASE) step(1'b0, 4'h4, 1'b0, 1'b0);
    chk("post-rst entry", 32'(entry_bcd), 32'h0004);

    // Randomized presses and glitches against the model.
    for (int n = 0; n < 200; n++) begin
      logic [3:0] code;
      code = 4'($urandom_range(0, 15));
      press(code, int'($urandom_range(1, 8)), int'(RELEASE + $urandom_range(0, 3)),
            int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
